reg_wb_ctrl: RTL and testbench

- Write-side controller for the 32x32 register file; sole driver of its single write port (we/waddr/wdata).
- Merges two result sources: the in-order MEM/WB pipeline and a long-latency unit (multiply/divide, uncached load).
- Long-latency results are buffered in a small FIFO; MEM/WB always has priority.
- Exposes a pending-write lookup so the hazard unit can stall reads of registers whose results are still queued.

---
 rtl/reg_wb_if.sv | 32 +++
 rtl/reg_wb_ctrl.sv | 112 +++++++++++
 tb/tb_reg_wb_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_if.sv
// Write-back bus bundle between the result sources, the hazard unit and reg_wb_ctrl.
// Long-latency handshake: an entry transfers on a posedge where lu_valid and lu_ready are both 1;
// lu_ready depends only on controller state, never on lu_valid.
interface reg_wb_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  logic                   pipe_we;
  logic [AW-1:0]          pipe_waddr;
  logic [DW-1:0]          pipe_wdata;
  logic                   lu_valid;
  logic                   lu_ready;
  logic [AW-1:0]          lu_waddr;
  logic [DW-1:0]          lu_wdata;
  logic [AW-1:0]          chk_addr;
  logic                   chk_hit;
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [DW-1:0]          wdata;
  logic [$clog2(DEPTH):0] fifo_cnt;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata, chk_addr,
    input  lu_ready, chk_hit, we, waddr, wdata, fifo_cnt
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata, chk_addr,
    output lu_ready, chk_hit, we, waddr, wdata, fifo_cnt
  );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port controller: MEM/WB has priority, long-latency results queue in a FIFO.
// Optional macro WB_BYPASS_EN lets a long-latency result go straight to an idle write port.
module reg_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic     clk,
  input  logic     rst,
  reg_wb_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic pipe_req, fifo_empty, lu_ready, push, pop, bypass, chk_hit;

  assign pipe_req   = bus.pipe_we && (bus.pipe_waddr != '0);
  assign fifo_empty = (cnt_q == '0);
  assign lu_ready   = !rst && (cnt_q < CW'(DEPTH));

`ifdef WB_BYPASS_EN
  assign bypass = !pipe_req && fifo_empty && bus.lu_valid && (bus.lu_waddr != '0);
`else
  assign bypass = 1'b0;
`endif

  // r0 writes complete the handshake but never occupy a slot.
  assign push = bus.lu_valid && lu_ready && (bus.lu_waddr != '0) && !bypass;
  assign pop  = !pipe_req && !fifo_empty;

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pipe_req) begin
      we_d    = 1'b1;
      waddr_d = bus.pipe_waddr;
      wdata_d = bus.pipe_wdata;
    end else if (pop) begin
      we_d    = 1'b1;
      waddr_d = addr_mem_q[rd_ptr_q];
      wdata_d = data_mem_q[rd_ptr_q];
    end else if (bypass) begin
      we_d    = 1'b1;
      waddr_d = bus.lu_waddr;
      wdata_d = bus.lu_wdata;
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.lu_waddr;
      data_mem_q[wr_ptr_q] <= bus.lu_wdata;
    end
  end

  // Only the cnt_q slots starting at the head hold live entries.
  always_comb begin
    chk_hit = 1'b0;
    if (!rst && (bus.chk_addr != '0)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < cnt_q) && (addr_mem_q[rd_ptr_q + PW'(k)] == bus.chk_addr))
          chk_hit = 1'b1;
      end
    end
  end

  assign bus.lu_ready = lu_ready;
  assign bus.chk_hit  = chk_hit;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.fifo_cnt = cnt_q;
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: fixed vector table, hand sequences and random traffic against a queue model.
// Expectations follow WB_BYPASS_EN when the bench is built with it.
module tb_reg_wb_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  reg_wb_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();
  reg_wb_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: ordered list of queued writes plus the write-port register
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t                mq[$];
  logic                m_we;
  logic [AW-1:0]       m_wa;
  logic [DW-1:0]       m_wd;
  logic [AW+DW-1:0]    exp_q[$];
  logic                s_rdy, s_hit;
  logic [2:0]          s_cnt;

  typedef struct {
    logic pwe; logic [AW-1:0] pa; logic [DW-1:0] pd;
    logic lv;  logic [AW-1:0] la; logic [DW-1:0] ld;
    logic [AW-1:0] ca;
    logic e_rdy; logic e_hit;
    logic e_we; logic [AW-1:0] e_wa; logic [DW-1:0] e_wd; logic [2:0] e_cnt;
  } vec_t;
  vec_t vecs[14];

  function automatic vec_t mk(logic pwe, logic [AW-1:0] pa, logic [DW-1:0] pd, logic lv,
                              logic [AW-1:0] la, logic [DW-1:0] ld, logic [AW-1:0] ca,
                              logic rdy, logic hit, logic we, logic [AW-1:0] wa,
                              logic [DW-1:0] wd, logic [2:0] cnt);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.pd = pd; v.lv = lv; v.la = la; v.ld = ld; v.ca = ca;
    v.e_rdy = rdy; v.e_hit = hit; v.e_we = we; v.e_wa = wa; v.e_wd = wd; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic bit in_q(logic [AW-1:0] a);
    foreach (mq[i]) if (mq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: starts and ends just after a posedge
  task automatic step(input logic pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input logic [AW-1:0] ca);
    bit m_rdy, m_hit, preq, byp;
    int m_cnt;
    ent_t e;
    bus.pipe_we = pwe; bus.pipe_waddr = pa; bus.pipe_wdata = pd;
    bus.lu_valid = lv; bus.lu_waddr = la;  bus.lu_wdata = ld;
    bus.chk_addr = ca;
    @(negedge clk);
    m_cnt = mq.size();
    m_rdy = (m_cnt < DEPTH);
    m_hit = (ca != 0) && in_q(ca);
    s_rdy = bus.lu_ready; s_hit = bus.chk_hit; s_cnt = bus.fifo_cnt;
    check("lu_ready", s_rdy, m_rdy);
    check("chk_hit", s_hit, m_hit);
    check("fifo_cnt", s_cnt, m_cnt);
    preq = pwe && (pa != 0);
    assert (!(preq && in_q(pa))) else $error("protocol violation: pipe write to queued r%0d", pa);
    @(posedge clk);
    byp  = 1'b0;
    m_we = 1'b1;
    if (preq) begin
      m_wa = pa; m_wd = pd;
    end else if (m_cnt > 0) begin
      e = mq.pop_front(); m_wa = e.a; m_wd = e.d;
    end else begin
`ifdef WB_BYPASS_EN
      byp = lv && (la != 0);
`endif
      if (byp) begin
        m_wa = la; m_wd = ld;
      end else begin
        m_we = 1'b0;
      end
    end
    if (lv && m_rdy && (la != 0) && !byp) begin
      e.a = la; e.d = ld; mq.push_back(e);
    end
    if (m_we) exp_q.push_back({m_wa, m_wd});
    #1;
    check("we", bus.we, m_we);
    if (bus.we === 1'b1) begin
      if (exp_q.size() > 0) check("write", {bus.waddr, bus.wdata}, exp_q.pop_front());
      else check("unexpected_write", 1, 0);
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check("hold_waddr", bus.waddr, m_wa);
      check("hold_wdata", bus.wdata, m_wd);
    end
  endtask

  task automatic idle(input logic [AW-1:0] ca);
    step(0, 0, 0, 0, 0, 0, ca);
  endtask

  task automatic do_reset(input logic [AW-1:0] ca);
    rst = 1'b1;
    bus.pipe_we = 0; bus.pipe_waddr = 0; bus.pipe_wdata = 0;
    bus.lu_valid = 0; bus.lu_waddr = 0; bus.lu_wdata = 0;
    bus.chk_addr = ca;
    @(negedge clk);
    check("rst_lu_ready", bus.lu_ready, 0);
    check("rst_chk_hit", bus.chk_hit, 0);
    @(posedge clk);
    #1;
    check("rst_we", bus.we, 0);
    check("rst_waddr", bus.waddr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_fifo_cnt", bus.fifo_cnt, 0);
    mq.delete(); exp_q.delete();
    m_we = 0; m_wa = 0; m_wd = 0;
    rst = 1'b0;
  endtask

  initial begin
    logic pwe, lv;
    logic [AW-1:0] pa, la, ca;
    rst = 1'b1;
    vecs[0]  = mk(1, 3,  'h1234, 0, 0, 0,     0, 1, 0, 1, 3,  'h1234, 0);
    vecs[1]  = mk(0, 0,  0,      0, 0, 0,     0, 1, 0, 0, 3,  'h1234, 0);
    vecs[2]  = mk(1, 0,  'hdead, 0, 0, 0,     0, 1, 0, 0, 3,  'h1234, 0);
    vecs[3]  = mk(0, 0,  0,      1, 0, 'h55,  0, 1, 0, 0, 3,  'h1234, 0);
    vecs[4]  = mk(1, 10, 'h100,  1, 1, 'h11,  0, 1, 0, 1, 10, 'h100,  1);
    vecs[5]  = mk(1, 11, 'h101,  1, 2, 'h12,  1, 1, 1, 1, 11, 'h101,  2);
    vecs[6]  = mk(1, 12, 'h102,  1, 3, 'h13,  2, 1, 1, 1, 12, 'h102,  3);
    vecs[7]  = mk(1, 13, 'h103,  1, 4, 'h14,  4, 1, 0, 1, 13, 'h103,  4);
    vecs[8]  = mk(1, 14, 'h104,  1, 9, 'h99,  4, 0, 1, 1, 14, 'h104,  4);
    vecs[9]  = mk(0, 0,  0,      1, 9, 'h99,  0, 0, 0, 1, 1,  'h11,   3);
    vecs[10] = mk(0, 0,  0,      0, 0, 0,     9, 1, 0, 1, 2,  'h12,   2);
    vecs[11] = mk(0, 0,  0,      0, 0, 0,     0, 1, 0, 1, 3,  'h13,   1);
    vecs[12] = mk(0, 0,  0,      0, 0, 0,     4, 1, 1, 1, 4,  'h14,   0);
    vecs[13] = mk(0, 0,  0,      0, 0, 0,     4, 1, 0, 0, 4,  'h14,   0);

    do_reset(0);

    foreach (vecs[i]) begin
      step(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].ca);
      check($sformatf("vec%0d_rdy", i), s_rdy, vecs[i].e_rdy);
      check($sformatf("vec%0d_hit", i), s_hit, vecs[i].e_hit);
      check($sformatf("vec%0d_we", i), bus.we, vecs[i].e_we);
      check($sformatf("vec%0d_waddr", i), bus.waddr, vecs[i].e_wa);
      check($sformatf("vec%0d_wdata", i), bus.wdata, vecs[i].e_wd);
      check($sformatf("vec%0d_cnt", i), bus.fifo_cnt, vecs[i].e_cnt);
    end

    // long-latency pair on an idle port
    step(0, 0, 0, 1, 5, 'hA, 0);
`ifdef WB_BYPASS_EN
    check("lu_r5_we", bus.we, 1);
    check("lu_r5_write", {bus.waddr, bus.wdata}, {5'd5, 32'hA});
    check("lu_r5_cnt", bus.fifo_cnt, 0);
`else
    check("lu_r5_we", bus.we, 0);
    check("lu_r5_cnt", bus.fifo_cnt, 1);
`endif
    step(0, 0, 0, 1, 6, 'hB, 0);
`ifdef WB_BYPASS_EN
    check("lu_r6_write", {bus.we, bus.waddr, bus.wdata}, {1'b1, 5'd6, 32'hB});
`else
    check("lu_r5_write", {bus.we, bus.waddr, bus.wdata}, {1'b1, 5'd5, 32'hA});
`endif
    idle(0);
`ifdef WB_BYPASS_EN
    check("lu_idle_we", bus.we, 0);
`else
    check("lu_r6_write", {bus.we, bus.waddr, bus.wdata}, {1'b1, 5'd6, 32'hB});
`endif
    idle(0);
    check("lu_drained_we", bus.we, 0);

    // pending-write lookup on r7
    step(1, 20, 'h200, 1, 7, 'h77, 0);
    check("r7_cnt", bus.fifo_cnt, 1);
    step(1, 21, 'h201, 0, 0, 0, 7);
    check("r7_hit", s_hit, 1);
    step(1, 22, 'h202, 0, 0, 0, 0);
    check("r0_hit", s_hit, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("r7_write", {bus.we, bus.waddr, bus.wdata}, {1'b1, 5'd7, 32'h77});
    idle(7);
    check("r7_hit_after", s_hit, 0);

    // reset with three queued entries
    step(1, 10, 'h300, 1, 1, 'h31, 0);
    step(1, 11, 'h301, 1, 2, 'h32, 0);
    step(1, 12, 'h302, 1, 3, 'h33, 0);
    check("pre_rst_cnt", bus.fifo_cnt, 3);
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      idle(2);
      check("post_rst_we", bus.we, 0);
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      pwe = $urandom_range(0, 1);
      pa  = $urandom_range(0, 31);
      if (in_q(pa)) pwe = 1'b0;
      lv  = ($urandom_range(0, 3) != 0);
      la  = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 31));
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        ca = mq[$urandom_range(0, mq.size() - 1)].a;
      else
        ca = $urandom_range(0, 31);
      step(pwe, pa, $urandom, lv, la, $urandom, ca);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(0);
    check("final_cnt", bus.fifo_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
